// File: rtl/xgs_powerup_sequencer.sv
// ---------------------------------------------------------------------------
// xgs_powerup_sequencer
// Autonomous AXI4-Lite master that releases the XGS sensor from reset after
// system reset: one write of the power-up value to the xgs_ctrl power-up
// register, then periodic polls of the status register until bit 0 is set or
// the poll timeout expires. Outcome is reported as sticky done/error flags.
// ---------------------------------------------------------------------------
module xgs_powerup_sequencer #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [31:0] CTRL_BASE      = 32'h0002_0000,
    parameter logic [31:0] PWRUP_OFFSET   = 32'h0000_0190,
    parameter logic [31:0] STATUS_OFFSET  = 32'h0000_0198,
    parameter logic [31:0] PWRUP_VALUE    = 32'h0000_0003,
    parameter int          POLL_GAP       = 16,
    parameter int          TIMEOUT        = 10000
) (
    input  logic                        axiClk100MHz,
    input  logic                        axiReset_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  error_code,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]                  m_axil_awprot,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]                  m_axil_arprot,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    // FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_RA   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;
    localparam logic [2:0] ST_ERR  = 3'd7;

    // Error codes reported on error_code
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BRESP   = 2'b01;
    localparam logic [1:0] ERR_RRESP   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Fixed transaction contents
    localparam logic [31:0]               PWRUP_ADDR_32  = CTRL_BASE + PWRUP_OFFSET;
    localparam logic [31:0]               STATUS_ADDR_32 = CTRL_BASE + STATUS_OFFSET;
    localparam logic [AXI_ADDR_WIDTH-1:0] PWRUP_ADDR     = AXI_ADDR_WIDTH'(PWRUP_ADDR_32);
    localparam logic [AXI_ADDR_WIDTH-1:0] STATUS_ADDR    = AXI_ADDR_WIDTH'(STATUS_ADDR_32);
    localparam logic [AXI_DATA_WIDTH-1:0] PWRUP_DATA     = AXI_DATA_WIDTH'(PWRUP_VALUE);

    // Poll gap counter runs 0 .. POLL_GAP-1
    localparam int             GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    // Timeout counter has one spare bit so it can pass TIMEOUT before saturating
    localparam int               TMO_W     = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};

    // Saturating increment for the timeout counter
    function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] cnt);
        logic [TMO_W-1:0] res;
        if (cnt == TMO_MAX) begin
            res = cnt;
        end else begin
            res = cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // State and output registers
    logic [2:0]                state_q,   state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q,  wvalid_d;
    logic                      bready_q,  bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q,  rready_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0]         wstrb_q,   wstrb_d;
    logic                      busy_q,    busy_d;
    logic                      done_q,    done_d;
    logic                      error_q,   error_d;
    logic [1:0]                ecode_q,   ecode_d;
    logic [TMO_W-1:0]          tmo_q,     tmo_d;
    logic [GAP_W-1:0]          gap_q,     gap_d;

    // Only bit 0 of the status word carries meaning
    logic unused_rdata_s;
    assign unused_rdata_s = ^m_axil_rdata[AXI_DATA_WIDTH-1:1];

    // Next-state and next-output logic for the power-up sequence
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        ecode_d   = ecode_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = PWRUP_ADDR;
                    wdata_d   = PWRUP_DATA;
                    wstrb_d   = {STRB_W{1'b1}};
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    ecode_d   = ERR_NONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
                // AW and W retire independently; leave once both are gone
                awvalid_d = awvalid_q & ~m_axil_awready;
                wvalid_d  = wvalid_q & ~m_axil_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end else begin
                    state_d = ST_WR;
                end
            end

            ST_WB: begin
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axil_bresp == RESP_OKAY) begin
                        state_d   = ST_RA;
                        arvalid_d = 1'b1;
                        araddr_d  = STATUS_ADDR;
                        tmo_d     = {TMO_W{1'b0}};
                    end else begin
                        state_d = ST_ERR;
                        ecode_d = ERR_BRESP;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_RA: begin
                tmo_d = tmo_inc(tmo_q);
                if (m_axil_arready) begin
                    state_d   = ST_RD;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d = ST_RA;
                end
            end

            ST_RD: begin
                tmo_d = tmo_inc(tmo_q);
                if (m_axil_rvalid) begin
                    rready_d = 1'b0;
                    if (m_axil_rresp != RESP_OKAY) begin
                        state_d = ST_ERR;
                        ecode_d = ERR_RRESP;
                    end else if (m_axil_rdata[0]) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = {GAP_W{1'b0}};
                    end
                end else begin
                    state_d = ST_RD;
                end
            end

            ST_GAP: begin
                // Timeout is only honoured here, never with a read in flight
                tmo_d = tmo_inc(tmo_q);
                if (tmo_q >= TMO_LIMIT) begin
                    state_d = ST_ERR;
                    ecode_d = ERR_TIMEOUT;
                end else if (gap_q == GAP_LAST) begin
                    state_d   = ST_RA;
                    arvalid_d = 1'b1;
                    araddr_d  = STATUS_ADDR;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end

            ST_ERR: begin
                state_d = ST_IDLE;
                error_d = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset abandons any transfer in flight
    always_ff @(posedge axiClk100MHz or negedge axiReset_n) begin
        if (!axiReset_n) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            araddr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            wdata_q   <= {AXI_DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ecode_q   <= ERR_NONE;
            tmo_q     <= {TMO_W{1'b0}};
            gap_q     <= {GAP_W{1'b0}};
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ecode_q   <= ecode_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign error_code     = ecode_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_xgs_powerup_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for xgs_powerup_sequencer: a behavioural AXI4-Lite slave with
// configurable ready delays and responses, plus a scoreboard of expected
// write/read addresses and data popped as handshakes occur.
// ---------------------------------------------------------------------------
module tb_xgs_powerup_sequencer;

    localparam logic [31:0] PWR_ADDR  = 32'h0002_0190;
    localparam logic [31:0] STAT_ADDR = 32'h0002_0198;
    localparam logic [31:0] PWR_DATA  = 32'h0000_0003;
    localparam int          GAP       = 16;
    localparam int          TMO       = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
    logic        m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
    logic [1:0]  m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
    logic [31:0] m_axil_rdata = 32'h0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave configuration
    int         aw_delay, w_delay, status_after, rresp_err_at;
    logic [1:0] bresp_cfg;
    bit         ar_free;
    // Monitor state
    int  aw_cnt, w_cnt, ar_cnt;
    int  aw_hs_n, w_hs_n, ar_hs_n, last_ar_cyc, first_ar_cyc, min_ar_gap;
    bit  aw_got, w_got, saw_w_first;
    bit  hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [31:0] exp_v;
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];

    xgs_powerup_sequencer #(
        .POLL_GAP (GAP),
        .TIMEOUT  (TMO)
    ) dut (
        .axiClk100MHz   (clk),
        .axiReset_n     (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .error_code     (error_code),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    always #5 clk = ~clk;

    // Slave model and scoreboard monitor: handshakes seen at negedge, slave
    // outputs updated just after each posedge
    initial begin : slave
        forever begin
            @(negedge clk);
            hs_aw = m_axil_awvalid && m_axil_awready;
            hs_w  = m_axil_wvalid && m_axil_wready;
            hs_b  = m_axil_bvalid && m_axil_bready;
            hs_ar = m_axil_arvalid && m_axil_arready;
            hs_r  = m_axil_rvalid && m_axil_rready;
            if (hs_aw) begin
                aw_hs_n++;
                aw_got = 1'b1;
                checks++;
                if (exp_aw_q.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: got awaddr %h, expected no write", m_axil_awaddr);
                end else begin
                    exp_v = exp_aw_q.pop_front();
                    if (m_axil_awaddr !== exp_v || m_axil_awprot !== 3'b000) begin
                        errors++;
                        $display("FAIL aw_addr: got %h prot %b, expected %h prot 000", m_axil_awaddr, m_axil_awprot, exp_v);
                    end
                end
            end
            if (hs_w) begin
                w_hs_n++;
                if (!aw_got) saw_w_first = 1'b1;
                w_got = 1'b1;
                checks++;
                if (exp_w_q.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected: got wdata %h, expected no write", m_axil_wdata);
                end else begin
                    exp_v = exp_w_q.pop_front();
                    if (m_axil_wdata !== exp_v || m_axil_wstrb !== 4'hF) begin
                        errors++;
                        $display("FAIL w_data: got %h strb %h, expected %h strb f", m_axil_wdata, m_axil_wstrb, exp_v);
                    end
                end
            end
            if (hs_ar) begin
                ar_hs_n++;
                if (last_ar_cyc >= 0 && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap = cyc - last_ar_cyc;
                if (first_ar_cyc < 0) first_ar_cyc = cyc;
                last_ar_cyc = cyc;
                checks++;
                if (ar_free) begin
                    exp_v = STAT_ADDR;
                end else if (exp_ar_q.size() == 0) begin
                    exp_v = 32'hDEAD_BEEF;
                    errors++;
                    $display("FAIL ar_unexpected: got araddr %h, expected no read", m_axil_araddr);
                end else begin
                    exp_v = exp_ar_q.pop_front();
                end
                if (exp_v != 32'hDEAD_BEEF && (m_axil_araddr !== exp_v || m_axil_arprot !== 3'b000
                        || m_axil_awvalid || m_axil_wvalid)) begin
                    errors++;
                    $display("FAIL ar_addr: got %h prot %b aw/w %b%b, expected %h prot 000 aw/w 00",
                             m_axil_araddr, m_axil_arprot, m_axil_awvalid, m_axil_wvalid, exp_v);
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
                m_axil_bvalid = 1'b0;  m_axil_rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
            end else begin
                if (m_axil_awvalid) begin
                    if (aw_cnt >= aw_delay) m_axil_awready = 1'b1;
                    else begin m_axil_awready = 1'b0; aw_cnt++; end
                end else begin m_axil_awready = 1'b0; aw_cnt = 0; end
                if (m_axil_wvalid) begin
                    if (w_cnt >= w_delay) m_axil_wready = 1'b1;
                    else begin m_axil_wready = 1'b0; w_cnt++; end
                end else begin m_axil_wready = 1'b0; w_cnt = 0; end
                m_axil_arready = m_axil_arvalid;
                if (hs_b) m_axil_bvalid = 1'b0;
                if (aw_got && w_got && !m_axil_bvalid) begin
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = bresp_cfg;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (hs_r) m_axil_rvalid = 1'b0;
                if (hs_ar) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = (status_after != 0 && ar_hs_n >= status_after) ? 32'h8000_0001 : 32'hFFFF_FFFE;
                    m_axil_rresp  = (ar_hs_n == rresp_err_at) ? 2'b11 : 2'b00;
                end
            end
        end
    end

    task automatic clear_sb();
        aw_delay = 0; w_delay = 0; status_after = 1; rresp_err_at = 0;
        bresp_cfg = 2'b00; ar_free = 1'b0;
        aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; saw_w_first = 1'b0;
        last_ar_cyc = -1; first_ar_cyc = -1; min_ar_gap = 1000000;
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    endtask

    task automatic push_write();
        exp_aw_q.push_back(PWR_ADDR);
        exp_w_q.push_back(PWR_DATA);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || error_code !== 2'b00 || busy !== 1'b1
                || m_axil_awvalid !== 1'b1 || m_axil_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL start_cycle: got done=%b err=%b code=%b busy=%b aw=%b w=%b, expected 0 0 00 1 1 1",
                     done, error, error_code, busy, m_axil_awvalid, m_axil_wvalid);
        end
    endtask

    task automatic wait_end(input int budget, output int n);
        n = 0;
        while (n < budget && !(done || error)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL end_wait: no done/error after %0d cycles, expected completion", n);
        end
    endtask

    task automatic drained(input string tag);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (exp_aw_q.size() != 0 || exp_w_q.size() != 0 || exp_ar_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got pending aw=%0d w=%0d ar=%0d, expected 0 0 0",
                     tag, exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size());
        end
    endtask

    task automatic test_reset();
        clear_sb();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready,
             busy, done, error, error_code, m_axil_awprot, m_axil_arprot, m_axil_wstrb} !== 19'd0
            || m_axil_awaddr !== 32'h0 || m_axil_araddr !== 32'h0 || m_axil_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: got aw=%b w=%b b=%b ar=%b r=%b busy=%b done=%b err=%b code=%b, expected all 0",
                     m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready,
                     busy, done, error, error_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_axil_awvalid !== 1'b0 || m_axil_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b aw=%b ar=%b, expected 0 0 0", busy, m_axil_awvalid, m_axil_arvalid);
        end
    endtask

    task automatic test_basic();
        int n;
        clear_sb();
        push_write();
        exp_ar_q.push_back(STAT_ADDR);
        do_start();
        wait_end(50, n);
        checks++;
        if (n != 5 || done !== 1'b1 || error !== 1'b0 || error_code !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got cycles=%0d done=%b err=%b code=%b busy=%b, expected 5 1 0 00 0",
                     n, done, error, error_code, busy);
        end
        drained("basic");
        checks++;
        if (aw_hs_n != 1 || w_hs_n != 1 || ar_hs_n != 1) begin
            errors++;
            $display("FAIL basic_counts: got aw=%0d w=%0d ar=%0d, expected 1 1 1", aw_hs_n, w_hs_n, ar_hs_n);
        end
    endtask

    task automatic test_w_before_aw();
        int n;
        clear_sb();
        aw_delay = 3;
        push_write();
        exp_ar_q.push_back(STAT_ADDR);
        do_start();
        wait_end(50, n);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || saw_w_first !== 1'b1 || aw_hs_n != 1 || w_hs_n != 1) begin
            errors++;
            $display("FAIL w_before_aw: got done=%b err=%b w_first=%b aw=%0d w=%0d, expected 1 0 1 1 1",
                     done, error, saw_w_first, aw_hs_n, w_hs_n);
        end
        drained("w_before_aw");
    endtask

    task automatic test_poll();
        int n;
        clear_sb();
        status_after = 4;
        push_write();
        repeat (4) exp_ar_q.push_back(STAT_ADDR);
        do_start();
        wait_end(300, n);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || ar_hs_n != 4 || min_ar_gap < GAP + 1) begin
            errors++;
            $display("FAIL poll: got done=%b err=%b reads=%0d min_gap=%0d, expected 1 0 4 >=%0d",
                     done, error, ar_hs_n, min_ar_gap, GAP + 1);
        end
        drained("poll");
    endtask

    task automatic test_back_to_back();
        int  rises;
        logic prev;
        clear_sb();
        repeat (2) begin
            push_write();
            exp_ar_q.push_back(STAT_ADDR);
        end
        rises = 0;
        prev  = done;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40 && rises < 2; i++) begin
            @(posedge clk);
            #1;
            if (done && !prev) rises++;
            prev = done;
        end
        start = 1'b0;
        drained("b2b");
        checks++;
        if (rises != 2 || aw_hs_n != 2 || ar_hs_n != 2) begin
            errors++;
            $display("FAIL back_to_back: got done_rises=%0d writes=%0d reads=%0d, expected 2 2 2", rises, aw_hs_n, ar_hs_n);
        end
    endtask

    task automatic test_timeout();
        int n;
        int span;
        clear_sb();
        status_after = 0;
        ar_free = 1'b1;
        push_write();
        do_start();
        wait_end(600, n);
        span = cyc - first_ar_cyc;
        checks++;
        if (error !== 1'b1 || error_code !== 2'b11 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got err=%b code=%b busy=%b done=%b, expected 1 11 0 0", error, error_code, busy, done);
        end
        checks++;
        if (m_axil_arvalid !== 1'b0 || m_axil_rready !== 1'b0 || m_axil_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_outstanding: got arvalid=%b rready=%b rvalid=%b, expected 0 0 0",
                     m_axil_arvalid, m_axil_rready, m_axil_rvalid);
        end
        checks++;
        if (span < TMO || span > TMO + GAP + 4) begin
            errors++;
            $display("FAIL timeout_span: got %0d cycles from first AR, expected %0d..%0d", span, TMO, TMO + GAP + 4);
        end
        drained("timeout");
    endtask

    task automatic test_bresp_err();
        int n;
        clear_sb();
        bresp_cfg = 2'b10;
        push_write();
        do_start();
        wait_end(50, n);
        checks++;
        if (error !== 1'b1 || error_code !== 2'b01 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bresp_err: got err=%b code=%b done=%b busy=%b, expected 1 01 0 0", error, error_code, done, busy);
        end
        drained("bresp");
        checks++;
        if (ar_hs_n != 0) begin
            errors++;
            $display("FAIL bresp_no_ar: got %0d reads, expected 0", ar_hs_n);
        end
    endtask

    task automatic test_rresp_err();
        int n;
        clear_sb();
        status_after = 0;
        rresp_err_at = 2;
        push_write();
        repeat (2) exp_ar_q.push_back(STAT_ADDR);
        do_start();
        wait_end(100, n);
        checks++;
        if (error !== 1'b1 || error_code !== 2'b10 || done !== 1'b0 || ar_hs_n != 2) begin
            errors++;
            $display("FAIL rresp_err: got err=%b code=%b done=%b reads=%0d, expected 1 10 0 2",
                     error, error_code, done, ar_hs_n);
        end
        drained("rresp");
    endtask

    task automatic test_reset_mid();
        int n;
        clear_sb();
        status_after = 0;
        ar_free = 1'b1;
        push_write();
        do_start();
        n = 0;
        while (n < 30 && m_axil_arvalid !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (m_axil_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_arvalid: got arvalid=%b after %0d cycles, expected 1", m_axil_arvalid, n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready,
             busy, done, error, error_code, m_axil_awprot, m_axil_arprot, m_axil_wstrb} !== 19'd0
            || m_axil_awaddr !== 32'h0 || m_axil_araddr !== 32'h0 || m_axil_wdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_values: got ar=%b r=%b busy=%b araddr=%h, expected 0 0 0 00000000",
                     m_axil_arvalid, m_axil_rready, busy, m_axil_araddr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_sb();
        push_write();
        exp_ar_q.push_back(STAT_ADDR);
        do_start();
        wait_end(50, n);
        checks++;
        if (n != 5 || done !== 1'b1 || error !== 1'b0 || error_code !== 2'b00) begin
            errors++;
            $display("FAIL after_reset_run: got cycles=%0d done=%b err=%b code=%b, expected 5 1 0 00", n, done, error, error_code);
        end
        drained("after_reset");
    endtask

    initial begin : main
        clear_sb();
        test_reset();
        test_basic();
        test_w_before_aw();
        test_poll();
        test_back_to_back();
        test_timeout();
        test_bresp_err();
        test_rresp_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
